// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the main control FSM and the multiply/divide sequencer.
// The master side is the control FSM, and the slave side is the sequencer.
interface muldiv_seq_if;
    logic start;
    logic op_div;
    logic src_mem;
    logic abort;
    logic zero_div_in;
    logic resetlocal;
    logic sel_mem;
    logic sel_div;
    logic hi_load;
    logic lo_load;
    logic busy;
    logic done;
    logic div_zero;

    modport master (
        output start, op_div, src_mem, abort, zero_div_in,
        input  resetlocal, sel_mem, sel_div, hi_load, lo_load, busy, done, div_zero
    );

    modport slave (
        input  start, op_div, src_mem, abort, zero_div_in,
        output resetlocal, sel_mem, sel_div, hi_load, lo_load, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequencer for the shared Mult/Div units: clear, counted run, divide-by-zero check, Hi/Lo write.
// Every output is either a register or a decode of the state register.
module muldiv_seq #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StWrite,
        StDone,
        StErr
    } state_e;

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_mem_q, sel_mem_d;
    logic             sel_div_q, sel_div_d;
    logic [CNT_W-1:0] run_load;
    logic             first_run;

    assign run_load  = sel_div_q ? DivLoad : MultLoad;
    // The counter only moves down from run_load, so equality marks the first RUN cycle.
    assign first_run = (cnt_q == run_load);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_mem_d = sel_mem_q;
        sel_div_d = sel_div_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sel_div_d = bus.op_div;
                    sel_mem_d = bus.src_mem;
                    state_d   = StClear;
                end
            end
            StClear: begin
                cnt_d   = run_load;
                state_d = StRun;
            end
            StRun: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (first_run && sel_div_q && bus.zero_div_in) begin
                    state_d = StErr;
                end else if (cnt_q == '0) begin
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort overrides every transition, so no pending write or status pulse survives it.
        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
        if (state_d == StIdle) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_mem_q <= 1'b0;
            sel_div_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_mem_q <= sel_mem_d;
            sel_div_q <= sel_div_d;
        end
    end

    assign bus.resetlocal = (state_q == StClear);
    assign bus.sel_mem    = sel_mem_q;
    assign bus.sel_div    = sel_div_q;
    assign bus.hi_load    = (state_q == StWrite);
    assign bus.lo_load    = (state_q == StWrite);
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.div_zero   = (state_q == StErr);
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: per-cycle output timelines plus a completion scoreboard.
// A second instance with short run lengths covers the reduced-parameter latency.
module tb_muldiv_seq;
    localparam int MultN  = 32;
    localparam int DivN   = 32;
    localparam int MultN1 = 3;
    localparam int DivN1  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic start_v   = 1'b0;
    logic op_div_v  = 1'b0;
    logic src_mem_v = 1'b0;
    logic abort_v   = 1'b0;
    logic zdiv_v    = 1'b0;
    logic dut_sel   = 1'b0;

    muldiv_seq_if bus0 ();
    muldiv_seq_if bus1 ();

    assign bus0.start       = start_v & ~dut_sel;
    assign bus0.op_div      = op_div_v;
    assign bus0.src_mem     = src_mem_v;
    assign bus0.abort       = abort_v & ~dut_sel;
    assign bus0.zero_div_in = zdiv_v;
    assign bus1.start       = start_v & dut_sel;
    assign bus1.op_div      = op_div_v;
    assign bus1.src_mem     = src_mem_v;
    assign bus1.abort       = abort_v & dut_sel;
    assign bus1.zero_div_in = zdiv_v;

    muldiv_seq #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN), .CNT_W(6)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    muldiv_seq #(.MULT_CYCLES(MultN1), .DIV_CYCLES(DivN1), .CNT_W(3)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Output vector: {resetlocal, sel_mem, sel_div, hi_load, lo_load, busy, done, div_zero}
    logic [7:0] v0, v1;
    assign v0 = {bus0.resetlocal, bus0.sel_mem, bus0.sel_div, bus0.hi_load, bus0.lo_load,
                 bus0.busy, bus0.done, bus0.div_zero};
    assign v1 = {bus1.resetlocal, bus1.sel_mem, bus1.sel_div, bus1.hi_load, bus1.lo_load,
                 bus1.busy, bus1.done, bus1.div_zero};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int cyc;
    } evt_t;
    evt_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    // Expected outputs in cycle T+k for an operation started at edge T.
    function automatic logic [7:0] exp_vec(input int k, input int n, input bit sd, input bit sm,
                                           input bit err, input int ab);
        logic rl, hl, bz, dn, dz;
        int   last;
        if (ab != 0 && k > ab) return {1'b0, sm, sd, 5'b0};
        last = err ? 3 : n + 3;
        rl   = (k == 1);
        bz   = (k >= 1) && (k <= last);
        hl   = !err && (k == n + 2);
        dn   = !err && (k == n + 3);
        dz   = err && (k == 3);
        return {rl, sm, sd, hl, hl, bz, dn, dz};
    endfunction

    // Called at a negedge in an idle cycle; start is sampled at the following posedge (edge T).
    task automatic run_op(input string tag, input bit on1, input bit od, input bit sm,
                          input int zd, input int ab, input bit ab0, input int xs,
                          input int rst_at, input int len);
        int         n, t0, evt_k;
        bit         err;
        logic [7:0] obs, ev;
        n     = on1 ? (od ? DivN1 : MultN1) : (od ? DivN : MultN);
        err   = od && (zd == 2);
        evt_k = err ? 3 : n + 3;
        t0    = cyc;
        if (!on1 && (ab == 0 || ab >= evt_k) && (rst_at == 0 || rst_at > evt_k))
            sb_q.push_back('{err, t0 + evt_k});
        dut_sel   = on1;
        start_v   = 1'b1;
        op_div_v  = od;
        src_mem_v = sm;
        abort_v   = ab0;
        zdiv_v    = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            obs = on1 ? v1 : v0;
            ev  = exp_vec(k, n, od, sm, err, ab);
            check($sformatf("%s_k%0d", tag, k), 32'(obs), 32'(ev));
            if (k == rst_at) begin
                start_v = 1'b0;
                abort_v = 1'b0;
                zdiv_v  = 1'b0;
                #1 reset = 1'b0;
                #1;
                check({tag, "_async_dut0"}, 32'(v0), 32'd0);
                check({tag, "_async_dut1"}, 32'(v1), 32'd0);
                return;
            end
            start_v   = (k == xs);
            op_div_v  = (k == xs) ? ~od : od;
            src_mem_v = (k == xs) ? ~sm : sm;
            abort_v   = (k == ab);
            zdiv_v    = (k == zd);
        end
    endtask

    always @(negedge clk) begin
        if (bus0.done || bus0.div_zero) begin
            check("excl_done_dz", 32'(bus0.done & bus0.div_zero), 32'd0);
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                evt_t e;
                e = sb_q.pop_front();
                check("sb_kind", 32'(bus0.div_zero), 32'(e.is_err));
                check("sb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_dut0", 32'(v0), 32'd0);
        check("reset_dut1", 32'(v1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        //      tag            dut od sm zd  ab       ab0 xs rst len
        run_op("mul_ab",        0, 0, 0, 0,  0,       0,  0, 0,  MultN + 4);
        run_op("divm_b2b",      0, 1, 1, 0,  0,       0,  0, 0,  DivN + 4);
        run_op("div_zero",      0, 1, 0, 2,  0,       0,  0, 0,  5);
        run_op("mul_zd_ign",    0, 0, 1, 2,  0,       1,  0, 0,  MultN + 4);
        run_op("div_zd_late",   0, 1, 0, 3,  0,       0,  0, 0,  DivN + 4);
        run_op("abort_run",     0, 0, 0, 0,  10,      0,  5, 0,  13);
        run_op("abort_write",   0, 1, 1, 0,  DivN + 2, 0, 0, 0,  DivN + 5);
        run_op("async_rst",     0, 0, 1, 0,  0,       0,  0, 20, 20);
        @(negedge clk);
        check("reset_held", 32'(v0), 32'd0);
        reset = 1'b1;
        run_op("mul_after_rst", 0, 0, 0, 0,  0,       0,  0, 0,  MultN + 4);
        run_op("small_mul",     1, 0, 0, 0,  0,       0,  0, 0,  MultN1 + 4);
        run_op("small_divm",    1, 1, 1, 0,  0,       0,  0, 0,  DivN1 + 4);
        run_op("small_dz",      1, 1, 0, 2,  0,       0,  0, 0,  5);
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
